mux_n1_reg: RTL and testbench

Parametrised, registered N-to-1 multiplexer with valid/ready flow control and selector-code checking. It is the datapath successor of the fixed six-input selector: it keeps the same 4-bit code-to-input mapping as the default, but is generalised in width, input count and code table. It adds an output register, backpressure and detection of unmapped selector codes. It sits at the ALU result-selection point and anywhere a registered, flow-controlled operand select is needed.

---
 rtl/mux_n1_reg.sv | 105 ++++++++++
 tb/tb_mux_n1_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n1_reg.sv
// Registered N-to-1 operand select with valid/ready handshake.
// Unmapped selector codes are flagged with a one-cycle pulse and counted.

module mux_n1_code_cmp #(
  parameter int SELW = 4
) (
  input  logic [SELW-1:0] code,
  input  logic [SELW-1:0] sel,
  output logic            hit
);
  assign hit = (code == sel);
endmodule

module mux_n1_reg #(
  parameter int               WIDTH = 32,
  parameter int               N     = 6,
  parameter int               SELW  = 4,
  parameter logic [N*SELW-1:0] CODES = {4'b1100, 4'b0111, 4'b0110, 4'b0010, 4'b0001, 4'b0000}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   entradas,
  input  logic [SELW-1:0]      seletor,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     saida,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 erro,
  output logic [7:0]           contagem_erros
);

  logic [N-1:0]     hit;
  logic             match;
  logic [WIDTH-1:0] pick;
  logic             accept;

  logic [WIDTH-1:0] saida_q, saida_d;
  logic             out_valid_q, out_valid_d;
  logic             erro_q, erro_d;
  logic [7:0]       cnt_q, cnt_d;

  // One comparator per table entry; all compare in parallel against seletor.
  for (genvar k = 0; k < N; k++) begin : g_cmp
    mux_n1_code_cmp #(.SELW(SELW)) u_cmp (
      .code (CODES[k*SELW +: SELW]),
      .sel  (seletor),
      .hit  (hit[k])
    );
  end

  // Walk from the top so the lowest matching index is the last one written.
  always_comb begin
    match = 1'b0;
    pick  = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (hit[k]) begin
        match = 1'b1;
        pick  = entradas[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    saida_d     = saida_q;
    out_valid_d = out_valid_q;
    erro_d      = 1'b0;
    cnt_d       = cnt_q;
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    if (accept) begin
      if (match) begin
        saida_d     = pick;
        out_valid_d = 1'b1;
      end else begin
        erro_d = 1'b1;
        if (cnt_q != 8'hFF)
          cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_q     <= '0;
      out_valid_q <= 1'b0;
      erro_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      saida_q     <= saida_d;
      out_valid_q <= out_valid_d;
      erro_q      <= erro_d;
      cnt_q       <= cnt_d;
    end
  end

  assign saida          = saida_q;
  assign out_valid      = out_valid_q;
  assign erro           = erro_q;
  assign contagem_erros = cnt_q;

endmodule

// File: tb/tb_mux_n1_reg.sv
// Bench for mux_n1_reg: default table, overridden priority table, and a narrow 2-input build.

module tb_mux_n1_reg;

  logic         clock = 1'b0;
  logic         reset;
  logic [191:0] entradas;
  logic [3:0]   seletor;
  logic         in_valid, in_ready, out_valid, out_ready, erro;
  logic [31:0]  saida;
  logic [7:0]   cnt;

  logic [3:0]   p_sel;
  logic         p_v, p_in_ready, p_out_valid, p_rdy, p_erro;
  logic [31:0]  p_saida;
  logic [7:0]   p_cnt;

  logic [15:0]  s_in;
  logic         s_sel, s_v, s_in_ready, s_out_valid, s_rdy, s_erro;
  logic [7:0]   s_saida;
  logic [7:0]   s_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  always #5 clock = ~clock;

  mux_n1_reg u_dut (
    .clock(clock), .reset(reset), .entradas(entradas), .seletor(seletor),
    .in_valid(in_valid), .in_ready(in_ready), .saida(saida), .out_valid(out_valid),
    .out_ready(out_ready), .erro(erro), .contagem_erros(cnt)
  );

  mux_n1_reg #(
    .CODES({4'b1100, 4'b0101, 4'b0110, 4'b0010, 4'b0101, 4'b0000})
  ) u_pri (
    .clock(clock), .reset(reset), .entradas(entradas), .seletor(p_sel),
    .in_valid(p_v), .in_ready(p_in_ready), .saida(p_saida), .out_valid(p_out_valid),
    .out_ready(p_rdy), .erro(p_erro), .contagem_erros(p_cnt)
  );

  mux_n1_reg #(.WIDTH(8), .N(2), .SELW(1), .CODES({1'b1, 1'b0})) u_small (
    .clock(clock), .reset(reset), .entradas(s_in), .seletor(s_sel),
    .in_valid(s_v), .in_ready(s_in_ready), .saida(s_saida), .out_valid(s_out_valid),
    .out_ready(s_rdy), .erro(s_erro), .contagem_erros(s_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int map_idx(input logic [3:0] s);
    logic [3:0] tab [6];
    tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    for (int k = 0; k < 6; k++)
      if (s == tab[k]) return k;
    return -1;
  endfunction

  // Scoreboard: pop and compare on consumption, push on a mapped accept.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got %h expected none pending", saida);
        end else begin
          chk("sb_data", saida, sb.pop_front());
        end
      end
      if (in_valid && in_ready && map_idx(seletor) >= 0)
        sb.push_back(entradas[map_idx(seletor)*32 +: 32]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  sel;
    logic        v;
    logic        rdy;
    logic        ev;
    logic [31:0] es;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  vec_t tab [13];
  logic [3:0] bp_sel [3];

  initial begin
    tab[0]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 8'd0};
    tab[1]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 32'h1000_0001, 1'b0, 8'd0};
    tab[2]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 32'h1000_0002, 1'b0, 8'd0};
    tab[3]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 32'h1000_0003, 1'b0, 8'd0};
    tab[4]  = '{4'b0111, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 1'b0, 8'd0};
    tab[5]  = '{4'b1100, 1'b1, 1'b1, 1'b1, 32'h1000_0005, 1'b0, 8'd0};
    tab[6]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 32'h1000_0003, 1'b0, 8'd0};
    tab[7]  = '{4'b0011, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 1'b1, 8'd1};
    tab[8]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 32'h1000_0003, 1'b0, 8'd1};
    tab[9]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 1'b1, 8'd2};
    tab[10] = '{4'b1000, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 1'b1, 8'd3};
    tab[11] = '{4'b0001, 1'b1, 1'b1, 1'b1, 32'h1000_0001, 1'b0, 8'd3};
    tab[12] = '{4'b0000, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 1'b0, 8'd3};
    bp_sel  = '{4'b0000, 4'b0111, 4'b0011};

    reset = 1'b1;
    for (int k = 0; k < 6; k++) entradas[k*32 +: 32] = 32'h1000_0000 + k;
    seletor = '0; in_valid = 1'b0; out_ready = 1'b0;
    p_sel = '0; p_v = 1'b0; p_rdy = 1'b1;
    s_in = {8'hB1, 8'hA0}; s_sel = 1'b0; s_v = 1'b0; s_rdy = 1'b1;

    step(); step();
    chk("rst_saida", saida, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_erro", {31'b0, erro}, 32'h0);
    chk("rst_cnt", {24'b0, cnt}, 32'h0);
    #3 reset = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    step();

    foreach (tab[i]) begin
      seletor = tab[i].sel; in_valid = tab[i].v; out_ready = tab[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tab[i].ev});
      chk($sformatf("vec%0d_saida", i), saida, tab[i].es);
      chk($sformatf("vec%0d_erro", i), {31'b0, erro}, {31'b0, tab[i].ee});
      chk($sformatf("vec%0d_cnt", i), {24'b0, cnt}, {24'b0, tab[i].ec});
    end

    // Backpressure: result must hold while the consumer stalls.
    seletor = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    step();
    chk("bp_load", saida, 32'h1000_0002);
    for (int j = 0; j < 3; j++) begin
      seletor = bp_sel[j];
      entradas[31:0] = 32'hDEAD_0000 + j;
      #1 chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      step();
      chk("bp_saida", saida, 32'h1000_0002);
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
    end
    chk("bp_cnt", {24'b0, cnt}, 32'd3);
    entradas[31:0] = 32'h1000_0000;
    seletor = 4'b1100; out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_swap_saida", saida, 32'h1000_0005);
    chk("bp_swap_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", {31'b0, out_valid}, 32'h0);

    // Priority on the overridden table: inputs 1 and 4 share 0101.
    chk("pri_ready", {31'b0, p_in_ready}, 32'h1);
    p_sel = 4'b0101; p_v = 1'b1;
    step();
    chk("pri_dup", p_saida, 32'h1000_0001);
    chk("pri_valid", {31'b0, p_out_valid}, 32'h1);
    p_sel = 4'b1100;
    step();
    chk("pri_top", p_saida, 32'h1000_0005);
    p_sel = 4'b0011;
    step();
    chk("pri_unmapped_erro", {31'b0, p_erro}, 32'h1);
    chk("pri_unmapped_cnt", {24'b0, p_cnt}, 32'd1);
    p_v = 1'b0;

    // Narrow build: every selector value is mapped.
    chk("small_ready", {31'b0, s_in_ready}, 32'h1);
    s_sel = 1'b0; s_v = 1'b1;
    step();
    chk("small_sel0", {24'b0, s_saida}, 32'hA0);
    s_sel = 1'b1;
    step();
    chk("small_sel1", {24'b0, s_saida}, 32'hB1);
    chk("small_valid", {31'b0, s_out_valid}, 32'h1);
    s_v = 1'b0;
    step();
    chk("small_erro", {31'b0, s_erro}, 32'h0);
    chk("small_cnt", {24'b0, s_cnt}, 32'h0);

    // Saturation of the unmapped counter.
    seletor = 4'b0011; in_valid = 1'b1; out_ready = 1'b1;
    repeat (260) step();
    chk("sat_cnt", {24'b0, cnt}, 32'd255);
    chk("sat_erro", {31'b0, erro}, 32'h1);
    chk("sat_saida", saida, 32'h1000_0005);
    in_valid = 1'b0;
    step();
    chk("sat_erro_clear", {31'b0, erro}, 32'h0);
    chk("sat_cnt_hold", {24'b0, cnt}, 32'd255);

    // Asynchronous reset while a result is held.
    seletor = 4'b0001; in_valid = 1'b1; out_ready = 1'b0;
    step();
    chk("ar_pre_saida", saida, 32'h1000_0001);
    #1 reset = 1'b1;
    #1;
    chk("ar_saida", saida, 32'h0);
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_erro", {31'b0, erro}, 32'h0);
    chk("ar_cnt", {24'b0, cnt}, 32'h0);
    sb.delete();
    #1 reset = 1'b0;
    chk("ar_in_ready", {31'b0, in_ready}, 32'h1);
    seletor = 4'b0111; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("ar_first_saida", saida, 32'h1000_0004);
    chk("ar_first_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    step(); step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
